// File: rtl/timer_irq_pkg.sv
// timer_irq_pkg: shared definitions for the timer compare/interrupt unit.
//   - default base address of the 4-register window and register offsets
//   - CTRL / STAT bit indices
//   - compare state machine encoding
package timer_irq_pkg;

    localparam logic [31:0] TIMER_IRQ_BASE   = 32'h4000_1000;

    localparam logic [3:0]  TIMER_CMP_OFF    = 4'h0;
    localparam logic [3:0]  TIMER_PERIOD_OFF = 4'h4;
    localparam logic [3:0]  TIMER_CTRL_OFF   = 4'h8;
    localparam logic [3:0]  TIMER_STAT_OFF   = 4'hC;

    localparam int unsigned TIMER_CTRL_EN       = 0;
    localparam int unsigned TIMER_CTRL_PERIODIC = 1;
    localparam int unsigned TIMER_CTRL_IE       = 2;
    localparam int unsigned TIMER_STAT_PENDING  = 0;

    localparam logic [31:0] TIMER_CMP_RESET    = 32'hFFFF_FFFF;
    localparam logic [31:0] TIMER_PERIOD_RESET = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } timer_state_e;

endpackage

// File: rtl/bytemask_reg.sv
// bytemask_reg: WIDTH-bit register with per-byte write enables and an
// asynchronous active-low reset to RESET_VAL.
//   clk, rst_n : clock, async active-low reset
//   we         : write strobe
//   mask       : byte enables, bit n covers bits 8n+7:8n
//   d          : write data
//   q          : register contents
module bytemask_reg #(
    parameter int unsigned     WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [(WIDTH+7)/8-1:0]   mask,
    input  logic [WIDTH-1:0]         d,
    output logic [WIDTH-1:0]         q
);

    logic [WIDTH-1:0] bit_en;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit_en
        assign bit_en[b] = mask[b/8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (we) begin
            q <= (q & ~bit_en) | (d & bit_en);
        end
    end

endmodule

// File: rtl/timer_irq.sv
// timer_irq: memory-mapped compare/interrupt unit fed by the system timer.
// Raises a registered level interrupt when the timer count reaches CMP,
// either once (one-shot) or repeatedly by adding PERIOD (periodic).
//   clk, rst_n  : clock, async active-low reset
//   i_rd, i_wr  : bus read / write strobes
//   i_addr      : byte address; window of 4 words at BASE_ADDR
//   i_wrmask    : byte enables for writes
//   i_data      : write data
//   i_timer     : current timer count
//   o_rd_valid  : read hit (combinational)
//   o_wr_valid  : write hit (combinational)
//   o_data      : read data, 0 when not read
//   o_irq       : interrupt request, registered
module timer_irq
    import timer_irq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TIMER_IRQ_BASE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_rd,
    input  logic [31:0] i_addr,
    input  logic        i_wr,
    input  logic [3:0]  i_wrmask,
    input  logic [31:0] i_data,
    input  logic [31:0] i_timer,
    output logic        o_rd_valid,
    output logic        o_wr_valid,
    output logic [31:0] o_data,
    output logic        o_irq
);

    // Address decode
    logic blk_hit;
    logic sel_cmp, sel_period, sel_ctrl, sel_stat, hit;

    assign blk_hit    = (i_addr[31:4] == BASE_ADDR[31:4]);
    assign sel_cmp    = blk_hit && (i_addr[3:0] == TIMER_CMP_OFF);
    assign sel_period = blk_hit && (i_addr[3:0] == TIMER_PERIOD_OFF);
    assign sel_ctrl   = blk_hit && (i_addr[3:0] == TIMER_CTRL_OFF);
    assign sel_stat   = blk_hit && (i_addr[3:0] == TIMER_STAT_OFF);
    assign hit        = sel_cmp | sel_period | sel_ctrl | sel_stat;

    assign o_rd_valid = i_rd & hit;
    assign o_wr_valid = i_wr & hit;

    logic cmp_wr, period_wr, ctrl_wr, stat_w1c;

    assign cmp_wr    = i_wr & sel_cmp;
    assign period_wr = i_wr & sel_period;
    assign ctrl_wr   = i_wr & sel_ctrl;
    assign stat_w1c  = i_wr & sel_stat & i_wrmask[0] & i_data[TIMER_STAT_PENDING];

    // Registers
    logic [31:0] cmp_q, period_q;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        pending_q, pending_d;
    logic        fire, advance;

    logic        cmp_we;
    logic [3:0]  cmp_mask;
    logic [31:0] cmp_din;

    // A bus write to CMP always beats the periodic reload in the same cycle.
    assign cmp_we   = cmp_wr | advance;
    assign cmp_mask = cmp_wr ? i_wrmask : 4'hF;
    assign cmp_din  = cmp_wr ? i_data : (cmp_q + period_q);

    bytemask_reg #(
        .WIDTH     (32),
        .RESET_VAL (TIMER_CMP_RESET)
    ) u_cmp (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (cmp_we),
        .mask  (cmp_mask),
        .d     (cmp_din),
        .q     (cmp_q)
    );

    bytemask_reg #(
        .WIDTH     (32),
        .RESET_VAL (TIMER_PERIOD_RESET)
    ) u_period (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (period_wr),
        .mask  (i_wrmask),
        .d     (i_data),
        .q     (period_q)
    );

    bytemask_reg #(
        .WIDTH     (3),
        .RESET_VAL (3'b000)
    ) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ctrl_wr),
        .mask  (i_wrmask[0]),
        .d     (i_data[2:0]),
        .q     (ctrl_q)
    );

    // Value CTRL will hold after this edge; state and o_irq follow it.
    assign ctrl_d = (ctrl_wr && i_wrmask[0]) ? i_data[2:0] : ctrl_q;

    // Wrap-safe match: count at or up to 2^31-1 ticks past CMP is reached.
    logic reached;
    assign reached = ($signed(i_timer - cmp_q) >= 32'sd0);

    // Compare state machine
    timer_state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ctrl_d[TIMER_CTRL_EN]) state_d = ARMED;
            end
            ARMED: begin
                if (reached && !cmp_wr) begin
                    fire = 1'b1;
                    if (ctrl_q[TIMER_CTRL_PERIODIC] && (period_q != '0)) begin
                        advance = 1'b1;
                    end else begin
                        state_d = FIRED;
                    end
                end
            end
            FIRED: begin
                if (cmp_wr) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase
        if (!ctrl_d[TIMER_CTRL_EN]) state_d = IDLE;
    end

    // Set beats write-1-to-clear.
    assign pending_d = fire | (pending_q & ~stat_w1c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            o_irq     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            o_irq     <= pending_d & ctrl_d[TIMER_CTRL_IE];
        end
    end

    // Read mux
    always_comb begin
        o_data = '0;
        if (o_rd_valid) begin
            unique case (1'b1)
                sel_cmp:    o_data = cmp_q;
                sel_period: o_data = period_q;
                sel_ctrl:   o_data = {29'd0, ctrl_q};
                sel_stat:   o_data = {31'd0, pending_q};
                default:    o_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_irq.sv
// Testbench for timer_irq: directed scenarios plus random bus traffic,
// checked against a behavioural model through an expectation queue.
module tb_timer_irq;

    localparam logic [31:0] BASE = 32'h4000_2000;

    logic        clk;
    logic        rst_n;
    logic        i_rd;
    logic [31:0] i_addr;
    logic        i_wr;
    logic [3:0]  i_wrmask;
    logic [31:0] i_data;
    logic [31:0] i_timer;
    logic        o_rd_valid;
    logic        o_wr_valid;
    logic [31:0] o_data;
    logic        o_irq;

    timer_irq #(.BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd       (i_rd),
        .i_addr     (i_addr),
        .i_wr       (i_wr),
        .i_wrmask   (i_wrmask),
        .i_data     (i_data),
        .i_timer    (i_timer),
        .o_rd_valid (o_rd_valid),
        .o_wr_valid (o_wr_valid),
        .o_data     (o_data),
        .o_irq      (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rdv;
        logic        wrv;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model: architectural registers plus enable / already-fired flags.
    logic [31:0] m_cmp, m_period;
    bit          m_en, m_per, m_ie, m_pend, m_done, m_irq;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] msk);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (msk[b]) r[8*b +: 8] = dat[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_cmp = 32'hFFFF_FFFF; m_period = '0;
        m_en = 0; m_per = 0; m_ie = 0; m_pend = 0; m_done = 0; m_irq = 0;
    endtask

    function automatic bit addr_hit(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off == 32'h0) || (off == 32'h4) || (off == 32'h8) || (off == 32'hC);
    endfunction

    task automatic model_step(input bit wr, input logic [31:0] addr, input logic [3:0] msk,
                              input logic [31:0] dat, input logic [31:0] tmr);
        bit          wh, cmpw, perw, ctlw, statw, reached, fire, reload;
        bit          n_en, n_per, n_ie;
        logic [31:0] off;
        wh    = wr && addr_hit(addr);
        off   = addr - BASE;
        cmpw  = wh && off == 32'h0;
        perw  = wh && off == 32'h4;
        ctlw  = wh && off == 32'h8;
        statw = wh && off == 32'hC;
        reached = (tmr - m_cmp) < 32'h8000_0000;
        fire    = m_en && !m_done && reached && !cmpw;
        reload  = fire && m_per && (m_period != 0);
        {n_ie, n_per, n_en} = {m_ie, m_per, m_en};
        if (ctlw && msk[0]) {n_ie, n_per, n_en} = dat[2:0];
        m_pend = fire || (m_pend && !(statw && msk[0] && dat[0]));
        if (cmpw) m_cmp = merge(m_cmp, dat, msk);
        else if (reload) m_cmp = m_cmp + m_period;
        if (perw) m_period = merge(m_period, dat, msk);
        if (fire && !reload) m_done = 1;
        if (cmpw) m_done = 0;
        if (!n_en) begin
            m_en = 0; m_done = 0;
        end else if (!m_en) begin
            m_en = 1; m_done = 0;
        end
        m_per = n_per;
        m_ie  = n_ie;
        m_irq = m_pend && m_ie;
    endtask

    // One bus cycle: drive inputs 2 time units after the edge, queue the
    // expected response, then advance the model to the next edge.
    task automatic cycle(input bit rst_v, input bit arst, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [3:0] msk,
                         input logic [31:0] dat, input logic [31:0] tmr);
        exp_t        e;
        logic [31:0] off;
        @(posedge clk);
        #2;
        i_rd = rd; i_wr = wr; i_addr = addr; i_wrmask = msk; i_data = dat; i_timer = tmr;
        if (arst) begin
            check("irq_before_async_reset", {31'd0, o_irq}, {31'd0, m_irq});
            rst_n = 1'b0;
            #1;
            check("irq_async_drop", {31'd0, o_irq}, 32'd0);
        end else begin
            rst_n = rst_v;
        end
        if (!rst_n) model_reset();
        off    = addr - BASE;
        e.rdv  = rd && addr_hit(addr);
        e.wrv  = wr && addr_hit(addr);
        e.data = '0;
        if (e.rdv) begin
            case (off)
                32'h0:   e.data = m_cmp;
                32'h4:   e.data = m_period;
                32'h8:   e.data = {29'd0, m_ie, m_per, m_en};
                default: e.data = {31'd0, m_pend};
            endcase
        end
        e.irq = m_irq;
        exp_q.push_back(e);
        if (rst_n) model_step(wr, addr, msk, dat, tmr);
    endtask

    // Monitor: compares DUT outputs mid-cycle against queued expectations.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rd_valid", {31'd0, o_rd_valid}, {31'd0, e.rdv});
            check("wr_valid", {31'd0, o_wr_valid}, {31'd0, e.wrv});
            check("rd_data",  o_data, e.data);
            check("irq",      {31'd0, o_irq}, {31'd0, e.irq});
        end
    end

    logic [31:0] t;

    task automatic idle(input logic [31:0] tmr);
        cycle(1, 0, 0, 0, BASE, 4'h0, 32'h0, tmr);
    endtask
    task automatic rd(input logic [3:0] off, input logic [31:0] tmr);
        cycle(1, 0, 1, 0, BASE + {28'd0, off}, 4'h0, 32'h0, tmr);
    endtask
    task automatic wr(input logic [3:0] off, input logic [3:0] msk, input logic [31:0] dat,
                      input logic [31:0] tmr);
        cycle(1, 0, 0, 1, BASE + {28'd0, off}, msk, dat, tmr);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; i_rd = 0; i_wr = 0; i_addr = '0; i_wrmask = '0; i_data = '0; i_timer = '0;
        model_reset();

        // Reset and reset values
        repeat (3) cycle(0, 0, 1, 0, BASE, 4'h0, 32'h0, 32'h0);
        rd(4'h0, 0); rd(4'h4, 0); rd(4'h8, 0); rd(4'hC, 0);
        cycle(1, 0, 1, 0, BASE + 32'h10, 4'h0, 32'h0, 0);
        cycle(1, 0, 1, 0, BASE + 32'h2, 4'h0, 32'h0, 0);
        cycle(1, 0, 0, 1, BASE + 32'h10, 4'hF, 32'h1234, 0);

        // One-shot
        wr(4'h0, 4'hF, 100, 80);
        wr(4'h8, 4'hF, 32'h5, 80);
        for (int unsigned v = 90; v <= 110; v++) rd(4'hC, v);
        wr(4'hC, 4'h1, 32'h1, 110);
        repeat (3) rd(4'hC, 111);

        // Periodic
        wr(4'h8, 4'hF, 32'h0, 0);
        wr(4'h0, 4'hF, 50, 0);
        wr(4'h4, 4'hF, 20, 0);
        wr(4'h8, 4'hF, 32'h7, 40);
        for (int unsigned v = 40; v <= 100; v++) begin
            if (m_pend) wr(4'hC, 4'h1, 32'h1, v);
            else rd(4'hC, v);
        end
        rd(4'h0, 100);

        // Wrap, one-shot
        t = 32'hFFFF_FFF0;
        wr(4'h8, 4'hF, 32'h0, t);
        wr(4'hC, 4'h1, 32'h1, t);
        wr(4'h0, 4'hF, 32'h5, t);
        wr(4'h8, 4'hF, 32'h5, t);
        t = 32'hFFFF_FFFE;
        for (int unsigned k = 0; k < 9; k++) begin
            rd(4'hC, t);
            t = t + 1;
        end
        // Wrap, periodic reload
        t = 32'hFFFF_FFF0;
        wr(4'h8, 4'hF, 32'h0, t);
        wr(4'hC, 4'h1, 32'h1, t);
        wr(4'h0, 4'hF, 32'hFFFF_FFF0, t);
        wr(4'h4, 4'hF, 32'h20, t);
        wr(4'h8, 4'hF, 32'h7, t);
        rd(4'h0, t);
        rd(4'h0, t);

        // Collisions
        wr(4'h8, 4'hF, 32'h0, 150);
        wr(4'hC, 4'h1, 32'h1, 150);
        wr(4'h4, 4'hF, 32'h0, 150);
        wr(4'h0, 4'hF, 200, 150);
        wr(4'h8, 4'hF, 32'h5, 199);
        rd(4'hC, 199);
        wr(4'h0, 4'hF, 300, 200);
        for (int unsigned v = 201; v <= 204; v++) rd(4'hC, v);
        wr(4'hC, 4'h1, 32'h1, 300);
        rd(4'hC, 301);
        wr(4'h0, 4'h1, 32'h0000_00AA, 302);
        rd(4'h0, 302);
        wr(4'h0, 4'h0, 32'hFFFF_FFFF, 302);
        rd(4'h0, 302);
        wr(4'h8, 4'hF, 32'h1, 302);
        rd(4'h8, 302);

        // Mid-operation asynchronous reset while o_irq is high
        wr(4'h8, 4'hF, 32'h5, 302);
        idle(302);
        cycle(0, 1, 0, 0, BASE, 4'h0, 32'h0, 302);
        cycle(0, 0, 1, 0, BASE + 32'h8, 4'h0, 32'h0, 32'hFFFF_FFFF);
        for (int unsigned k = 0; k < 4; k++) rd(4'hC, 32'hFFFF_FFFF);
        rd(4'h0, 32'hFFFF_FFFF);

        // Random traffic
        t = 32'd1000;
        for (int unsigned k = 0; k < 500; k++) begin
            int unsigned op, sel;
            logic [31:0] a, d;
            logic [3:0]  m;
            t   = t + $urandom_range(0, 3);
            op  = $urandom_range(0, 9);
            sel = $urandom_range(0, 6);
            case (sel)
                0: a = BASE;
                1: a = BASE + 32'h4;
                2: a = BASE + 32'h8;
                3: a = BASE + 32'hC;
                4: a = BASE + 32'h10;
                5: a = BASE + 32'h6;
                default: a = BASE ^ 32'h0100_0000;
            endcase
            m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            case (sel)
                0: d = t + $urandom_range(0, 30);
                1: d = $urandom_range(0, 8);
                2: d = ($urandom_range(0, 7) == 0) ? 32'($urandom) : {29'd0, 3'($urandom)};
                default: d = $urandom;
            endcase
            if (op < 4) cycle(1, 0, 1, 0, a, 4'h0, 32'h0, t);
            else if (op < 7) cycle(1, 0, $urandom_range(0, 1) == 1, 1, a, m, d, t);
            else idle(t);
        end

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
